// File: rtl/alu_share_ctrl.sv
// alu_share_ctrl: round-robin sequencer sharing one combinational ALU between two clients
//   Ports: clk/rst (async active-high); c0_*/c1_* valid/sel/a/b in, ready/done out;
//   res_data captured result; busy when not IDLE; alu_a/alu_b/alu_sel to ALU, alu_result from ALU.
//   Define ALU_SHARE_FLAGS_EN to add res_zero/res_neg registered alongside res_data.
module alu_share_ctrl #(
  parameter int WIDTH  = 16,
  parameter int SETTLE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             c0_valid,
  input  logic [2:0]       c0_sel,
  input  logic [WIDTH-1:0] c0_a,
  input  logic [WIDTH-1:0] c0_b,
  output logic             c0_ready,
  output logic             c0_done,
  input  logic             c1_valid,
  input  logic [2:0]       c1_sel,
  input  logic [WIDTH-1:0] c1_a,
  input  logic [WIDTH-1:0] c1_b,
  output logic             c1_ready,
  output logic             c1_done,
  output logic [WIDTH-1:0] res_data,
  output logic             busy,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_sel,
  input  logic [WIDTH-1:0] alu_result
`ifdef ALU_SHARE_FLAGS_EN
  ,
  output logic             res_zero,
  output logic             res_neg
`endif
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t           r_state;
  logic [3:0]       r_cnt;
  logic             r_last;
  logic             r_c0_done, r_c1_done;
  logic [WIDTH-1:0] r_res, r_a, r_b;
  logic [2:0]       r_sel;
  logic             w_idle, w_grant0, w_grant1;
`ifdef ALU_SHARE_FLAGS_EN
  logic             r_zero, r_neg;
  assign res_zero = r_zero;
  assign res_neg  = r_neg;
`endif
  // r_last also names the owner of the op in flight; 1 after reset so client 0 wins first
  assign w_idle   = ~rst & (r_state == IDLE);
  assign w_grant0 = w_idle & c0_valid & (~c1_valid | r_last);
  assign w_grant1 = w_idle & c1_valid & ~w_grant0;
  assign c0_ready = w_grant0;
  assign c1_ready = w_grant1;
  assign c0_done  = r_c0_done;
  assign c1_done  = r_c1_done;
  assign res_data = r_res;
  assign busy     = r_state != IDLE;
  assign alu_a    = r_a;
  assign alu_b    = r_b;
  assign alu_sel  = r_sel;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_last    <= 1'b1;
      r_c0_done <= 1'b0;
      r_c1_done <= 1'b0;
      r_res     <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_sel     <= '0;
`ifdef ALU_SHARE_FLAGS_EN
      r_zero    <= 1'b0;
      r_neg     <= 1'b0;
`endif
    end else begin
      r_c0_done <= 1'b0;
      r_c1_done <= 1'b0;
      unique case (r_state)
        IDLE: if (w_grant0 | w_grant1) begin
          r_a     <= w_grant0 ? c0_a : c1_a;
          r_b     <= w_grant0 ? c0_b : c1_b;
          r_sel   <= w_grant0 ? c0_sel : c1_sel;
          r_last  <= w_grant1;
          r_cnt   <= 4'(SETTLE - 1);
          r_state <= EXEC;
        end
        EXEC: if (r_cnt == 4'd0) begin
          r_res     <= alu_result;
`ifdef ALU_SHARE_FLAGS_EN
          r_zero    <= alu_result == '0;
          r_neg     <= alu_result[WIDTH-1];
`endif
          r_c0_done <= ~r_last;
          r_c1_done <= r_last;
          r_state   <= RESP;
        end else begin
          r_cnt <= r_cnt - 4'd1;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_share_ctrl.sv
// tb_alu_share_ctrl: directed self-checking bench for alu_share_ctrl (SETTLE=1 and SETTLE=4 instances)
module tb_alu_share_ctrl;
  logic        clk = 1'b0, rst = 1'b1;
  logic [2:0]  c0_sel = '0, c1_sel = '0;
  logic [15:0] c0_a = '0, c0_b = '0, c1_a = '0, c1_b = '0;
  logic        v0_1 = 1'b0, v1_1 = 1'b0, v0_4 = 1'b0, v1_4 = 1'b0;
  logic        r0_1, r1_1, d0_1, d1_1, busy_1, r0_4, r1_4, d0_4, d1_4, busy_4;
  logic [15:0] res_1, a_1, b_1, alu_r_1, res_4, a_4, b_4, alu_r_4;
  logic [2:0]  sel_1, sel_4;
`ifdef ALU_SHARE_FLAGS_EN
  logic        z_1, n_1, z_4, n_4;
`endif
  int n_vec = 0, n_err = 0;
  always #5 clk = ~clk;
  always_comb alu_r_1 = sel_1 == 3'd0 ? a_1 + b_1 : sel_1 == 3'd1 ? a_1 - b_1 : a_1 & b_1;
  always_comb alu_r_4 = sel_4 == 3'd0 ? a_4 + b_4 : sel_4 == 3'd1 ? a_4 - b_4 : a_4 & b_4;
  alu_share_ctrl #(.WIDTH(16), .SETTLE(1)) dut1 (
    .clk(clk), .rst(rst),
    .c0_valid(v0_1), .c0_sel(c0_sel), .c0_a(c0_a), .c0_b(c0_b), .c0_ready(r0_1), .c0_done(d0_1),
    .c1_valid(v1_1), .c1_sel(c1_sel), .c1_a(c1_a), .c1_b(c1_b), .c1_ready(r1_1), .c1_done(d1_1),
    .res_data(res_1), .busy(busy_1), .alu_a(a_1), .alu_b(b_1), .alu_sel(sel_1), .alu_result(alu_r_1)
`ifdef ALU_SHARE_FLAGS_EN
    , .res_zero(z_1), .res_neg(n_1)
`endif
  );
  alu_share_ctrl #(.WIDTH(16), .SETTLE(4)) dut4 (
    .clk(clk), .rst(rst),
    .c0_valid(v0_4), .c0_sel(c0_sel), .c0_a(c0_a), .c0_b(c0_b), .c0_ready(r0_4), .c0_done(d0_4),
    .c1_valid(v1_4), .c1_sel(c1_sel), .c1_a(c1_a), .c1_b(c1_b), .c1_ready(r1_4), .c1_done(d1_4),
    .res_data(res_4), .busy(busy_4), .alu_a(a_4), .alu_b(b_4), .alu_sel(sel_4), .alu_result(alu_r_4)
`ifdef ALU_SHARE_FLAGS_EN
    , .res_zero(z_4), .res_neg(n_4)
`endif
  );
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    n_vec++; if ({busy_1, r0_1, r1_1, d0_1, d1_1} !== 5'b0) begin n_err++; $display("FAIL reset_ctl1 got %b want 00000", {busy_1, r0_1, r1_1, d0_1, d1_1}); end
    n_vec++; if ({res_1, a_1, b_1, sel_1} !== 51'b0) begin n_err++; $display("FAIL reset_data1 got res=%h a=%h b=%h sel=%h want 0", res_1, a_1, b_1, sel_1); end
    n_vec++; if ({busy_4, res_4, a_4} !== 33'b0) begin n_err++; $display("FAIL reset_dut4 got busy=%b res=%h a=%h want 0", busy_4, res_4, a_4); end
`ifdef ALU_SHARE_FLAGS_EN
    n_vec++; if ({z_1, n_1} !== 2'b00) begin n_err++; $display("FAIL reset_flags got %b want 00", {z_1, n_1}); end
`endif
    rst = 1'b0;
  endtask
  task automatic test_single_op();
    c0_sel = 3'd0; c0_a = 16'h0005; c0_b = 16'h0003; v0_1 = 1'b1;
    #1;
    n_vec++; if ({r0_1, r1_1} !== 2'b10) begin n_err++; $display("FAIL single_ready got %b want 10", {r0_1, r1_1}); end
    tick();
    v0_1 = 1'b0;
    n_vec++; if ({busy_1, d0_1, a_1, b_1} !== {2'b10, 16'h0005, 16'h0003}) begin n_err++; $display("FAIL single_exec got busy=%b done=%b a=%h b=%h want 1 0 0005 0003", busy_1, d0_1, a_1, b_1); end
    tick();
    n_vec++; if ({d0_1, d1_1, res_1} !== {2'b10, 16'h0008}) begin n_err++; $display("FAIL single_done got d0=%b d1=%b res=%h want 1 0 0008", d0_1, d1_1, res_1); end
    tick();
    n_vec++; if ({busy_1, d0_1, res_1, a_1} !== {2'b00, 16'h0008, 16'h0005}) begin n_err++; $display("FAIL single_hold got busy=%b d0=%b res=%h a=%h want 0 0 0008 0005", busy_1, d0_1, res_1, a_1); end
  endtask
  task automatic test_sub_wrap();
    c1_sel = 3'd1; c1_a = 16'h0000; c1_b = 16'h0001; v1_1 = 1'b1;
    #1;
    n_vec++; if ({r0_1, r1_1} !== 2'b01) begin n_err++; $display("FAIL sub_ready got %b want 01", {r0_1, r1_1}); end
    tick();
    v1_1 = 1'b0;
    tick();
    n_vec++; if ({d0_1, d1_1, res_1} !== {2'b01, 16'hFFFF}) begin n_err++; $display("FAIL sub_done got d0=%b d1=%b res=%h want 0 1 ffff", d0_1, d1_1, res_1); end
`ifdef ALU_SHARE_FLAGS_EN
    n_vec++; if ({z_1, n_1} !== 2'b01) begin n_err++; $display("FAIL sub_flags got zero/neg=%b want 01", {z_1, n_1}); end
`endif
    tick();
  endtask
  task automatic test_contention();
    rst = 1'b1;
    c0_sel = 3'd0; c0_a = 16'h0005; c0_b = 16'h0003;
    c1_sel = 3'd1; c1_a = 16'h0000; c1_b = 16'h0001;
    v0_1 = 1'b1; v1_1 = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    for (int k = 0; k < 12; k++) begin
      n_vec++; if ({r0_1, r1_1} !== {k % 3 == 0 && (k / 3) % 2 == 0, k % 3 == 0 && (k / 3) % 2 == 1})
        begin n_err++; $display("FAIL contend_ready k=%0d got %b", k, {r0_1, r1_1}); end
      n_vec++; if ({d0_1, d1_1} !== {k % 3 == 2 && (k / 3) % 2 == 0, k % 3 == 2 && (k / 3) % 2 == 1})
        begin n_err++; $display("FAIL contend_done k=%0d got %b", k, {d0_1, d1_1}); end
      if (k % 3 == 2) begin
        n_vec++; if (res_1 !== ((k / 3) % 2 == 0 ? 16'h0008 : 16'hFFFF))
          begin n_err++; $display("FAIL contend_res k=%0d got %h", k, res_1); end
      end
      tick();
    end
    v0_1 = 1'b0; v1_1 = 1'b0;
    tick();
  endtask
  task automatic test_settle();
    c0_sel = 3'd0; c0_a = 16'h1234; c0_b = 16'h1111; v0_4 = 1'b1;
    #1;
    n_vec++; if (r0_4 !== 1'b1) begin n_err++; $display("FAIL settle_ready got %b want 1", r0_4); end
    tick();
    v0_4 = 1'b0; c0_a = 16'h0000; c0_b = 16'h0000;
    for (int i = 0; i < 4; i++) begin
      n_vec++; if ({busy_4, d0_4, a_4, b_4} !== {2'b10, 16'h1234, 16'h1111})
        begin n_err++; $display("FAIL settle_exec i=%0d got busy=%b done=%b a=%h b=%h want 1 0 1234 1111", i, busy_4, d0_4, a_4, b_4); end
      tick();
    end
    n_vec++; if ({d0_4, d1_4, res_4} !== {2'b10, 16'h2345}) begin n_err++; $display("FAIL settle_done got d0=%b d1=%b res=%h want 1 0 2345", d0_4, d1_4, res_4); end
`ifdef ALU_SHARE_FLAGS_EN
    n_vec++; if ({z_4, n_4} !== 2'b00) begin n_err++; $display("FAIL settle_flags got %b want 00", {z_4, n_4}); end
`endif
    tick();
    n_vec++; if ({busy_4, d0_4} !== 2'b00) begin n_err++; $display("FAIL settle_idle got %b want 00", {busy_4, d0_4}); end
  endtask
  task automatic test_reset_midop();
    c0_sel = 3'd0; c0_a = 16'h0005; c0_b = 16'h0003; v0_1 = 1'b1;
    tick();
    v0_1 = 1'b0;
    rst = 1'b1;
    #1;
    n_vec++; if ({busy_1, d0_1, d1_1, res_1, a_1, b_1, sel_1} !== 54'b0)
      begin n_err++; $display("FAIL midrst_clear got busy=%b d=%b%b res=%h a=%h b=%h sel=%h want 0", busy_1, d0_1, d1_1, res_1, a_1, b_1, sel_1); end
    v0_1 = 1'b1; v1_1 = 1'b1;
    #1;
    n_vec++; if ({r0_1, r1_1} !== 2'b00) begin n_err++; $display("FAIL midrst_ready_in_reset got %b want 00", {r0_1, r1_1}); end
    tick();
    n_vec++; if ({d0_1, d1_1} !== 2'b00) begin n_err++; $display("FAIL midrst_no_done got %b want 00", {d0_1, d1_1}); end
    rst = 1'b0;
    #1;
    n_vec++; if ({r0_1, r1_1} !== 2'b10) begin n_err++; $display("FAIL midrst_first_grant got %b want 10", {r0_1, r1_1}); end
    tick();
    v0_1 = 1'b0; v1_1 = 1'b0;
    tick();
    n_vec++; if ({d0_1, d1_1, res_1} !== {2'b10, 16'h0008}) begin n_err++; $display("FAIL midrst_after got d=%b%b res=%h want 10 0008", d0_1, d1_1, res_1); end
    tick();
  endtask
  task automatic test_zero_flag();
    c0_sel = 3'd1; c0_a = 16'h00AA; c0_b = 16'h00AA; v0_1 = 1'b1;
    tick();
    v0_1 = 1'b0;
    tick();
    n_vec++; if ({d0_1, res_1} !== {1'b1, 16'h0000}) begin n_err++; $display("FAIL zero_res got d0=%b res=%h want 1 0000", d0_1, res_1); end
`ifdef ALU_SHARE_FLAGS_EN
    n_vec++; if ({z_1, n_1} !== 2'b10) begin n_err++; $display("FAIL zero_flags got %b want 10", {z_1, n_1}); end
`endif
    tick();
  endtask
  initial begin
    test_reset();
    test_single_op();
    test_sub_wrap();
    test_contention();
    test_settle();
    test_reset_midop();
    test_zero_flag();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
